// File: rtl/lc3b_cache_pkg.sv
// Shared geometry, types and helpers for the two-way LC-3b cache.
package lc3b_cache_pkg;

  localparam int unsigned NumSets = 8;

  typedef logic [8:0]   lc3b_c_tag;
  typedef logic [2:0]   lc3b_c_index;
  typedef logic [3:0]   lc3b_c_offset;
  typedef logic [2:0]   lc3b_c_word;
  typedef logic [127:0] lc3b_c_line;

  typedef enum logic [1:0] {StCheck, StWb, StAlloc} lc3b_c_state_e;

  function automatic lc3b_c_line merge_bytes(input lc3b_c_line  line,
                                             input lc3b_c_word  sel,
                                             input logic [15:0] wdata,
                                             input logic [1:0]  be);
    lc3b_c_line merged;
    merged = line;
    if (be[0]) merged[{sel, 4'h0} +: 8] = wdata[7:0];
    if (be[1]) merged[{sel, 4'h8} +: 8] = wdata[15:8];
    return merged;
  endfunction

endpackage

// File: rtl/lc3b_cache_way.sv
// One cache way: valid/dirty/tag/data arrays with line-load and byte-merge write modes.
module lc3b_cache_way
  import lc3b_cache_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  lc3b_c_index index_i,
  input  logic        load_i,
  input  logic        merge_i,
  input  lc3b_c_tag   tag_i,
  input  lc3b_c_line  line_i,
  input  lc3b_c_word  word_sel_i,
  input  logic [15:0] wdata_i,
  input  logic [1:0]  be_i,
  output logic        valid_o,
  output logic        dirty_o,
  output lc3b_c_tag   tag_o,
  output lc3b_c_line  line_o
);

  logic [NumSets-1:0] valid_q;
  logic [NumSets-1:0] dirty_q;
  lc3b_c_tag          tag_q  [NumSets];
  lc3b_c_line         data_q [NumSets];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (load_i) begin
      valid_q[index_i] <= 1'b1;
      dirty_q[index_i] <= 1'b0;
    end else if (merge_i) begin
      dirty_q[index_i] <= 1'b1;
    end
  end

  // Tag and data storage are deliberately left uncleared by reset.
  always_ff @(posedge clk_i) begin
    if (load_i) begin
      tag_q[index_i]  <= tag_i;
      data_q[index_i] <= line_i;
    end else if (merge_i) begin
      data_q[index_i] <= merge_bytes(data_q[index_i], word_sel_i, wdata_i, be_i);
    end
  end

  assign valid_o = valid_q[index_i];
  assign dirty_o = dirty_q[index_i];
  assign tag_o   = tag_q[index_i];
  assign line_o  = data_q[index_i];

endmodule

// File: rtl/lc3b_cache.sv
// Two-way set-associative write-back cache for the LC-3b; FSM, LRU and hit/victim logic.
// Define LC3B_CACHE_PERF_EN to add hit/miss/write-back counter outputs.
module lc3b_cache
  import lc3b_cache_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic [15:0]  mem_address,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [1:0]   mem_byte_enable,
  input  logic [15:0]  mem_wdata,
  output logic [15:0]  mem_rdata,
  output logic         mem_resp,
  output logic [15:0]  pmem_address,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [127:0] pmem_wdata,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp
`ifdef LC3B_CACHE_PERF_EN
  ,
  output logic [15:0]  hit_count,
  output logic [15:0]  miss_count,
  output logic [15:0]  wb_count
`endif
);

  lc3b_c_tag     addr_tag;
  lc3b_c_index   addr_index;
  lc3b_c_word    addr_word;
  logic          unused_addr_lsb;
  logic          req;

  assign addr_tag        = mem_address[15:7];
  assign addr_index      = mem_address[6:4];
  assign addr_word       = mem_address[3:1];
  assign unused_addr_lsb = mem_address[0];
  assign req             = mem_read | mem_write;

  lc3b_c_state_e state_q, state_d;
  logic          victim_q, victim_d;
  logic [NumSets-1:0] lru_q, lru_d;
  lc3b_c_tag     miss_tag_q, miss_tag_d;
  lc3b_c_index   miss_index_q, miss_index_d;

  logic [1:0]    way_valid, way_dirty, way_load, way_merge, hit;
  lc3b_c_tag     way_tag  [2];
  lc3b_c_line    way_line [2];
  lc3b_c_index   rd_index;
  logic          hit_way, victim_sel;
  logic          miss_event, wb_event;

  // Outside S_CHECK the arrays are addressed by the latched miss, not the live CPU address.
  assign rd_index = (state_q == StCheck) ? addr_index : miss_index_q;

  lc3b_cache_way u_way0 (
    .clk_i      (clk),
    .reset_i    (reset),
    .index_i    (rd_index),
    .load_i     (way_load[0]),
    .merge_i    (way_merge[0]),
    .tag_i      (miss_tag_q),
    .line_i     (pmem_rdata),
    .word_sel_i (addr_word),
    .wdata_i    (mem_wdata),
    .be_i       (mem_byte_enable),
    .valid_o    (way_valid[0]),
    .dirty_o    (way_dirty[0]),
    .tag_o      (way_tag[0]),
    .line_o     (way_line[0])
  );

  lc3b_cache_way u_way1 (
    .clk_i      (clk),
    .reset_i    (reset),
    .index_i    (rd_index),
    .load_i     (way_load[1]),
    .merge_i    (way_merge[1]),
    .tag_i      (miss_tag_q),
    .line_i     (pmem_rdata),
    .word_sel_i (addr_word),
    .wdata_i    (mem_wdata),
    .be_i       (mem_byte_enable),
    .valid_o    (way_valid[1]),
    .dirty_o    (way_dirty[1]),
    .tag_o      (way_tag[1]),
    .line_o     (way_line[1])
  );

  assign hit[0]     = way_valid[0] && (way_tag[0] == addr_tag);
  assign hit[1]     = way_valid[1] && (way_tag[1] == addr_tag);
  assign hit_way    = ~hit[0];
  assign victim_sel = !way_valid[0] ? 1'b0 :
                      !way_valid[1] ? 1'b1 : lru_q[addr_index];

  always_comb begin
    state_d      = state_q;
    victim_d     = victim_q;
    lru_d        = lru_q;
    miss_tag_d   = miss_tag_q;
    miss_index_d = miss_index_q;
    way_load     = '0;
    way_merge    = '0;
    mem_resp     = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    miss_event   = 1'b0;
    wb_event     = 1'b0;
    mem_rdata    = way_line[hit_way][{addr_word, 4'h0} +: 16];

    unique case (state_q)
      StCheck: begin
        if (req) begin
          if (hit != 2'b00) begin
            mem_resp              = 1'b1;
            lru_d[addr_index]     = ~hit_way;
            way_merge[hit_way]    = mem_write;
          end else begin
            miss_event   = 1'b1;
            victim_d     = victim_sel;
            miss_tag_d   = addr_tag;
            miss_index_d = addr_index;
            state_d      = (way_valid[victim_sel] && way_dirty[victim_sel]) ? StWb : StAlloc;
          end
        end
      end
      StWb: begin
        pmem_write   = 1'b1;
        pmem_address = {way_tag[victim_q], miss_index_q, 4'h0};
        pmem_wdata   = way_line[victim_q];
        if (pmem_resp) begin
          wb_event = 1'b1;
          state_d  = StAlloc;
        end
      end
      StAlloc: begin
        pmem_read    = 1'b1;
        pmem_address = {miss_tag_q, miss_index_q, 4'h0};
        if (pmem_resp) begin
          way_load[victim_q] = 1'b1;
          state_d            = StCheck;
        end
      end
      default: state_d = StCheck;
    endcase

    if (reset) begin
      mem_resp   = 1'b0;
      pmem_read  = 1'b0;
      pmem_write = 1'b0;
      way_load   = '0;
      way_merge  = '0;
      miss_event = 1'b0;
      wb_event   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StCheck;
      victim_q     <= 1'b0;
      lru_q        <= '0;
      miss_tag_q   <= '0;
      miss_index_q <= '0;
    end else begin
      state_q      <= state_d;
      victim_q     <= victim_d;
      lru_q        <= lru_d;
      miss_tag_q   <= miss_tag_d;
      miss_index_q <= miss_index_d;
    end
  end

`ifdef LC3B_CACHE_PERF_EN
  logic [15:0] hit_q, miss_q, wb_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_q  <= '0;
      miss_q <= '0;
      wb_q   <= '0;
    end else begin
      if (mem_resp)   hit_q  <= hit_q + 16'd1;
      if (miss_event) miss_q <= miss_q + 16'd1;
      if (wb_event)   wb_q   <= wb_q + 16'd1;
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
  assign wb_count   = wb_q;
`else
  logic unused_perf_events;
  assign unused_perf_events = miss_event ^ wb_event;
`endif

endmodule

// File: doc/lc3b_cache.md
# lc3b_cache

Two-way set-associative, write-back, write-allocate cache between the LC-3b multicycle control/datapath and physical memory. It accepts the CPU's 16-bit word/byte memory handshake (mem_read, mem_write, mem_byte_enable, mem_resp) and services misses through a 128-bit line-wide physical memory port. It holds 8 sets × 2 ways × 16-byte lines (256 B) with one LRU bit per set.

## Interface
Parameters: none; geometry is fixed by package constants.

Ports:
- clk  in  1  system clock; all state updates on posedge. One clock; reset is synchronous and active-high.
- reset  in  1  synchronous, active-high reset.
- mem_address  in  16  CPU byte address.
- mem_read  in  1  CPU read request, held until mem_resp.
- mem_write  in  1  CPU write request, held until mem_resp.
- mem_byte_enable  in  2  bit0 = low byte, bit1 = high byte of the addressed word.
- mem_wdata  in  16  CPU write data.
- mem_rdata  out  16  addressed word of the hit line.
- mem_resp  out  1  one-cycle completion strobe.
- pmem_address  out  16  line address, low 4 bits always 0.
- pmem_read  out  1  line fill request, held until pmem_resp.
- pmem_write  out  1  line write-back request, held until pmem_resp.
- pmem_wdata  out  128  victim line data.
- pmem_rdata  in  128  fill data, valid with pmem_resp.
- pmem_resp  in  1  physical memory completion strobe.

## Operation
- Address split: tag = addr[15:7] (9 b), index = addr[6:4] (3 b), offset = addr[3:0]; word select = offset[3:1]; offset[0] ignored.
- Per way per set: valid, dirty, tag, 128-bit data. Per set: lru bit (names the way to replace).
- States: S_CHECK, S_WB, S_ALLOC.
- S_CHECK, no request: idle, all outputs 0 except mem_rdata (don't care).
- S_CHECK, request, hit in way w: mem_resp = 1 this cycle; mem_rdata = selected word of way w; lru[index] <= ~w. On write hit: merge enabled bytes into selected word, dirty[w] <= 1. Stay in S_CHECK.
- S_CHECK, request, miss: victim = way 0 if invalid, else way 1 if invalid, else lru[index]. Victim valid and dirty -> S_WB, else -> S_ALLOC. mem_resp = 0.
- S_WB: pmem_write = 1, pmem_address = {victim tag, index, 4'b0}, pmem_wdata = victim line. On pmem_resp -> S_ALLOC.
- S_ALLOC: pmem_read = 1, pmem_address = {tag, index, 4'b0}. On pmem_resp: write pmem_rdata into victim way, tag <= tag, valid <= 1, dirty <= 0 -> S_CHECK (request then hits).
- mem_read and mem_write both high: treated as write (cpu_control never does this).
- Request deasserted mid-miss: the miss completes (line filled); no mem_resp issued.
- Victim way is latched on leaving S_CHECK and held through S_WB/S_ALLOC.

## Timing
- Reset: state <= S_CHECK; all valid, dirty, lru <= 0; while reset is high, mem_resp, pmem_read and pmem_write are forced 0. Data/tag arrays are not cleared.
- Hit latency: mem_resp in the first cycle the request is seen (combinational compare); array/LRU/dirty update at that cycle's edge.
- Clean miss: 1 (S_CHECK) + N_fill + 1 (hit) cycles, where N_fill = pmem cycles up to and including pmem_resp.
- Dirty miss: adds N_wb cycles before the fill.
- pmem_read and pmem_write are never high together; each drops in the cycle after pmem_resp.
- Reset mid-miss abandons the transaction; pmem strobes drop the next cycle.
- mem_resp is high for exactly one cycle per completed request.

## Configuration
- LC3B_CACHE_PERF_EN defined: adds outputs hit_count, miss_count and wb_count (16 b each, wrapping, cleared by reset). These increment on a hit mem_resp, on a S_CHECK-to-miss transition, and on S_WB completion respectively.
- Undefined: these ports and counters are absent. Behaviour is otherwise identical.

## Structure
- lc3b_types additions: lc3b_c_tag (9 b), lc3b_c_index (3 b), lc3b_c_offset (4 b), lc3b_c_line (128 b), and a cache state enum.
- Sub-module cache_way: one instance per way, holding valid/dirty/tag/data arrays. It has a write port with line-load and byte-merge modes and a combinational read by index. The top level holds the FSM, lru array, hit/victim logic and muxes.

## Test plan
- Cold read 0x1234 with pmem returning line L (word 2 = 0xBEEF): pmem_read is issued at 0x1230, and mem_rdata = 0xBEEF with mem_resp 1 cycle after pmem_resp; a repeat read hits in 1 cycle with no pmem activity.
- Byte write 0x1235 = 0x00AB with mem_byte_enable 2'b10 after the fill: a hit; a read of 0x1234 then returns 0xABEF and the line is dirty.
- Reads of 0x1230, 0x1330 and 0x1430 (same index 3): the third evicts the LRU way (0x1230's). The dirty victim gives pmem_write at 0x1230 with the merged line before pmem_read at 0x1430.
- Clean eviction: no pmem_write is issued, only pmem_read.
- Reset asserted while in S_WB: pmem_write drops. A following read of 0x1230 misses, because valid was cleared.
- With LC3B_CACHE_PERF_EN: after the above sequence, hit_count, miss_count and wb_count match the scoreboard tally.
